// File: rtl/lattice_sched_pkg.sv
// Shared definitions for the lattice nonce scheduler.
//   sched_state_t : scheduler FSM states
//   num_cores     : cores per issue derived from LOG2_NUM_CORES
//   last_nonce    : base nonce of the final issue, 2**nonce_bits - num_cores
package lattice_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  function automatic int unsigned num_cores(input int unsigned log2_num_cores);
    return 32'd1 << log2_num_cores;
  endfunction

  // Computed as (2**nb - 1) - (cores - 1) so no intermediate needs nb+1 bits.
  function automatic logic [63:0] last_nonce(input int unsigned nonce_bits,
                                             input int unsigned log2_num_cores);
    logic [63:0] mask;
    mask = (nonce_bits >= 64) ? '1 : ((64'd1 << nonce_bits) - 64'd1);
    return mask - (64'(num_cores(log2_num_cores)) - 64'd1);
  endfunction

endpackage

// File: rtl/lattice_inflight_counter.sv
// Up/down counter of issues outstanding in the lattice pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : one issue entered the pipeline this cycle
//   dec      : one result left the pipeline this cycle
//   count    : current outstanding count
//   full     : count == MAX_COUNT
//   empty    : count == 0
// inc and dec together leave the count unchanged; dec at zero is ignored.
module lattice_inflight_counter #(
  parameter int unsigned MAX_COUNT = 64,
  parameter int unsigned CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  assign full  = (count == CW'(MAX_COUNT));
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (!full) count <= count + CW'(1);
    end else if (dec && !inc) begin
      if (!empty) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/lattice_nonce_scheduler.sv
// Sequences one nonce-search job at a time into the lattice pipeline.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   job_valid/ready   : host job handshake (ready while idle)
//   abort             : level, cancels the current job
//   stall             : lattice cannot accept an issue (gates next cycle)
//   issue_valid/newBlock/nonce : registered issue to the first lattice block
//   result_valid/success/nonce : one result per issue from the last block
//   found_valid/nonce : first winning nonce of the current/last job
//   done              : one-cycle pulse at job completion
//   busy              : job in progress
module lattice_nonce_scheduler
  import lattice_sched_pkg::*;
#(
  parameter int unsigned LOG2_NUM_CORES = 1,
  parameter int unsigned NONCE_BITS     = 32,
  parameter int unsigned MAX_INFLIGHT   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic                  abort,
  input  logic                  stall,
  output logic                  issue_valid,
  output logic                  issue_newBlock,
  output logic [NONCE_BITS-1:0] issue_nonce,
  input  logic                  result_valid,
  input  logic                  result_success,
  input  logic [NONCE_BITS-1:0] result_nonce,
  output logic                  found_valid,
  output logic [NONCE_BITS-1:0] found_nonce,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned NUM_CORES = num_cores(LOG2_NUM_CORES);
  localparam int unsigned CW        = $clog2(MAX_INFLIGHT + 1);
  localparam logic [NONCE_BITS-1:0] NONCE_STEP = NONCE_BITS'(NUM_CORES);
  localparam logic [NONCE_BITS-1:0] LAST_NONCE =
    NONCE_BITS'(last_nonce(NONCE_BITS, LOG2_NUM_CORES));

  sched_state_t          state, state_n;
  logic [NONCE_BITS-1:0] next_nonce, next_nonce_n;
  logic [NONCE_BITS-1:0] issue_nonce_n, found_nonce_n;
  logic                  issue_valid_n, issue_newblock_n, found_valid_n;
  logic                  aborted, aborted_n;
  logic [CW-1:0]         outstanding;
  logic                  cnt_full, cnt_empty;
  logic                  active, room, issue_ok, found_hit;

  lattice_inflight_counter #(
    .MAX_COUNT (MAX_INFLIGHT),
    .CW        (CW)
  ) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .inc   (issue_valid),
    .dec   (result_valid && (state != IDLE)),
    .count (outstanding),
    .full  (cnt_full),
    .empty (cnt_empty)
  );

  assign job_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign active    = (state == RUN) || (state == DRAIN);

  // Equivalent to outstanding + issue_valid < MAX_INFLIGHT, since the
  // registered issue is not yet in the count.
  assign room = !cnt_full &&
                !(issue_valid && (outstanding == CW'(MAX_INFLIGHT - 1)));

  assign found_hit = result_valid && result_success && active &&
                     !aborted && !abort && !found_valid;

  always_comb begin
    state_n          = state;
    issue_valid_n    = 1'b0;
    issue_newblock_n = 1'b0;
    issue_nonce_n    = issue_nonce;
    next_nonce_n     = next_nonce;
    found_valid_n    = found_valid;
    found_nonce_n    = found_nonce;
    aborted_n        = aborted;
    issue_ok         = 1'b0;

    if (found_hit) begin
      found_valid_n = 1'b1;
      found_nonce_n = result_nonce;
    end
    if (abort && active) aborted_n = 1'b1;

    case (state)
      IDLE: begin
        if (job_valid) begin
          state_n          = RUN;
          found_valid_n    = 1'b0;
          found_nonce_n    = '0;
          aborted_n        = 1'b0;
          issue_valid_n    = 1'b1;
          issue_newblock_n = 1'b1;
          issue_nonce_n    = '0;
          // Nonce 0 is consumed by the newBlock issue itself.
          next_nonce_n     = NONCE_STEP;
        end
      end
      RUN: begin
        issue_ok = !stall && !abort && !found_valid && room;
        if (issue_ok) begin
          issue_valid_n = 1'b1;
          issue_nonce_n = next_nonce;
          next_nonce_n  = next_nonce + NONCE_STEP;
        end
        if (abort || found_valid || (issue_ok && (next_nonce == LAST_NONCE)))
          state_n = DRAIN;
      end
      DRAIN: begin
        if (cnt_empty && !issue_valid) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      issue_valid    <= 1'b0;
      issue_newBlock <= 1'b0;
      issue_nonce    <= '0;
      next_nonce     <= '0;
      found_valid    <= 1'b0;
      found_nonce    <= '0;
      aborted        <= 1'b0;
    end else begin
      state          <= state_n;
      issue_valid    <= issue_valid_n;
      issue_newBlock <= issue_newblock_n;
      issue_nonce    <= issue_nonce_n;
      next_nonce     <= next_nonce_n;
      found_valid    <= found_valid_n;
      found_nonce    <= found_nonce_n;
      aborted        <= aborted_n;
    end
  end

endmodule

// File: tb/tb_lattice_nonce_scheduler.sv
// Self-checking bench for lattice_nonce_scheduler: a main instance
// (MAX_INFLIGHT=64) and a small-window instance (MAX_INFLIGHT=4) share the
// lattice-side inputs; the bench plays the lattice, returning results in
// order a fixed delay after each issue, and predicts outcomes per job.
module tb_lattice_nonce_scheduler;

  localparam int unsigned NB    = 4;
  localparam int unsigned L2    = 1;
  localparam int unsigned TOTAL = 8;   // 2**NB / 2**L2 issues per job
  localparam logic [NB-1:0] STEP = 4'd2;

  logic clk = 1'b0;
  logic rst;
  logic jv_a, jv_b, abort, stall, rv, rs;
  logic [NB-1:0] rn;
  logic ready_a, iv_a, nb_a, fv_a, done_a, busy_a;
  logic ready_b, iv_b, nb_b, fv_b, done_b, busy_b;
  logic [NB-1:0] nonce_a, fn_a, nonce_b, fn_b;

  always #5 clk = ~clk;

  lattice_nonce_scheduler #(.LOG2_NUM_CORES(L2), .NONCE_BITS(NB), .MAX_INFLIGHT(64)) dut (
    .clk(clk), .rst(rst), .job_valid(jv_a), .job_ready(ready_a), .abort(abort),
    .stall(stall), .issue_valid(iv_a), .issue_newBlock(nb_a), .issue_nonce(nonce_a),
    .result_valid(rv), .result_success(rs), .result_nonce(rn),
    .found_valid(fv_a), .found_nonce(fn_a), .done(done_a), .busy(busy_a));

  lattice_nonce_scheduler #(.LOG2_NUM_CORES(L2), .NONCE_BITS(NB), .MAX_INFLIGHT(4)) dut_lim (
    .clk(clk), .rst(rst), .job_valid(jv_b), .job_ready(ready_b), .abort(abort),
    .stall(stall), .issue_valid(iv_b), .issue_newBlock(nb_b), .issue_nonce(nonce_b),
    .result_valid(rv), .result_success(rs), .result_nonce(rn),
    .found_valid(fv_b), .found_nonce(fn_b), .done(done_b), .busy(busy_b));

  typedef struct {
    int unsigned   due;
    logic [NB-1:0] nonce;
    int unsigned   idx;
  } pend_t;

  pend_t q[$];
  int unsigned vectors = 0, miscompares = 0, cyc = 0;

  // job configuration
  bit sel = 0, want_job = 0, hold = 0, strict = 0, succ_en = 0, abort_w_succ = 0;
  int unsigned dly = 1, smode = 0, succ_idx = 0, cur_max = 64;
  // reference model state
  bit job_active = 0, exp_found = 0, m_aborted = 0, done_seen = 0, prev_stall = 0;
  int unsigned issued = 0, returned = 0, accept_cyc = 0, last_res = 0;
  int unsigned no_issue_from = '1, drain_start = '1;
  logic [NB-1:0] exp_nonce = '0, exp_fnonce = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe outputs of this cycle at the falling edge,
  // update the model, then drive this cycle's inputs.
  task automatic step();
    logic o_iv, o_nb, o_fv, o_done, o_busy, o_ready;
    logic [NB-1:0] o_nonce, o_fn;
    bit succ;
    int unsigned exp_done;
    pend_t e;
    @(negedge clk);
    cyc++;
    o_iv    = sel ? iv_b    : iv_a;
    o_nb    = sel ? nb_b    : nb_a;
    o_nonce = sel ? nonce_b : nonce_a;
    o_fv    = sel ? fv_b    : fv_a;
    o_fn    = sel ? fn_b    : fn_a;
    o_done  = sel ? done_b  : done_a;
    o_busy  = sel ? busy_b  : busy_a;
    o_ready = sel ? ready_b : ready_a;

    if (job_active) begin
      if (cyc == accept_cyc + 1) chk("first_issue", 32'(o_iv), 32'(1));
      else begin
        if (strict) chk("issue_slot", 32'(o_iv), 32'((issued < TOTAL) && !prev_stall));
        chk("stall_gate", 32'(o_iv && prev_stall), 32'(0));
      end
      chk("issue_cutoff", 32'(o_iv && (cyc >= no_issue_from)), 32'(0));
      chk("busy_run", 32'(o_busy), 32'(1));
      if (o_iv) begin
        chk("issue_nonce", 32'(o_nonce), 32'(exp_nonce));
        chk("issue_newblock", 32'(o_nb), 32'(issued == 0));
        chk("inflight_limit", 32'((issued + 1 - returned) <= cur_max), 32'(1));
        q.push_back('{due: cyc + dly, nonce: exp_nonce, idx: issued});
        issued++;
        exp_nonce = exp_nonce + STEP;
        if (issued == TOTAL && cyc < drain_start) drain_start = cyc;
      end
      if (o_done) begin
        exp_done = ((last_res + 1 > drain_start) ? last_res + 1 : drain_start) + 1;
        chk("done_time", cyc, exp_done);
        chk("done_found_valid", 32'(o_fv), 32'(exp_found));
        if (exp_found) chk("done_found_nonce", 32'(o_fn), 32'(exp_fnonce));
        if (strict) chk("issue_total", issued, TOTAL);
        done_seen  = 1;
        job_active = 0;
      end
    end else if (!rst) begin
      chk("idle_ready", 32'(o_ready), 32'(1));
      chk("idle_busy", 32'(o_busy), 32'(0));
      chk("idle_issue", 32'(o_iv), 32'(0));
      chk("idle_done", 32'(o_done), 32'(0));
      chk("idle_found_valid", 32'(o_fv), 32'(exp_found));
      if (exp_found) chk("idle_found_nonce", 32'(o_fn), 32'(exp_fnonce));
    end

    jv_a = 0; jv_b = 0; rv = 0; rs = 0; rn = '0; abort = 0; stall = 0;
    if (want_job) begin
      want_job = 0; job_active = 1; accept_cyc = cyc;
      issued = 0; returned = 0; last_res = 0; exp_nonce = '0;
      exp_found = 0; exp_fnonce = '0; m_aborted = 0;
      no_issue_from = '1; drain_start = '1;
      if (sel) jv_b = 1; else jv_a = 1;
      stall = (smode != 0);   // first issue must ignore stall
    end else if (job_active) begin
      case (smode)
        1: stall = ($urandom_range(0, 3) == 0);
        2: stall = (issued >= 3);
        3: stall = (cyc >= accept_cyc + 3) && (cyc < accept_cyc + 6);
        default: stall = 0;
      endcase
    end

    if (q.size() != 0 && !hold && q[0].due <= cyc) begin
      e = q.pop_front();
      rv = 1; rn = e.nonce + 4'd1; returned++; last_res = cyc;
      // late results from an abandoned job are all marked successful
      succ = job_active ? (succ_en && (e.idx == succ_idx || e.idx == succ_idx + 1)) : 1'b1;
      rs = succ;
      if (succ && job_active) begin
        if (abort_w_succ && !m_aborted) begin
          abort = 1; m_aborted = 1;
          if (cyc + 1 < no_issue_from) no_issue_from = cyc + 1;
          if (cyc + 1 < drain_start) drain_start = cyc + 1;
        end else if (!m_aborted && !exp_found) begin
          exp_found = 1; exp_fnonce = rn;
          if (cyc + 2 < no_issue_from) no_issue_from = cyc + 2;
          if (cyc + 2 < drain_start) drain_start = cyc + 2;
        end
      end
    end
    prev_stall = stall;
  endtask

  task automatic start_job(input bit s_sel, input int unsigned s_dly, input int unsigned s_smode,
                           input bit s_succ, input int unsigned s_idx, input bit s_abort,
                           input bit s_strict);
    sel = s_sel; dly = s_dly; smode = s_smode; succ_en = s_succ; succ_idx = s_idx;
    abort_w_succ = s_abort; strict = s_strict; cur_max = s_sel ? 4 : 64;
    done_seen = 0; want_job = 1;
    step();
  endtask

  task automatic wait_done(input int unsigned limit);
    for (int unsigned i = 0; i < limit && !done_seen; i++) step();
    chk("done_timeout", 32'(done_seen), 32'(1));
    job_active = 0;
  endtask

  initial begin
    rst = 1; jv_a = 0; jv_b = 0; abort = 0; stall = 0; rv = 0; rs = 0; rn = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_a), 32'(1));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_issue", 32'({iv_a, nb_a, nonce_a}), 32'(0));
    chk("rst_found", 32'({fv_a, fn_a}), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_lim", 32'({ready_b, busy_b, iv_b}), 32'(3'b100));
    #1 rst = 0;

    // exhaust, no stall, results 5 cycles after issue
    start_job(0, 5, 0, 0, 0, 0, 1);
    wait_done(100);
    // success on nonce 6 (second success on nonce 8 must be ignored)
    start_job(0, 5, 0, 1, 3, 0, 0);
    wait_done(100);
    chk("success_nonce", 32'(fn_a), 32'(7));
    // three stall cycles mid-run
    start_job(0, 3, 3, 0, 0, 0, 1);
    wait_done(100);
    // abort together with success
    start_job(0, $urandom_range(1, 4), 0, 1, $urandom_range(0, 2), 1, 0);
    wait_done(100);
    // randomized jobs
    for (int unsigned j = 0; j < 8; j++) begin
      bit rs_en, ra;
      rs_en = 1'($urandom_range(0, 1));
      ra    = rs_en ? 1'($urandom_range(0, 1)) : 1'b0;
      start_job(0, $urandom_range(1, 8), 1, rs_en, $urandom_range(0, 6), ra, !rs_en);
      wait_done(200);
    end

    // in-flight window of 4 with results withheld
    hold = 1;
    start_job(1, 1, 0, 0, 0, 0, 0);
    repeat (10) step();
    chk("inflight_hold", issued, 4);
    hold = 0;
    wait_done(100);
    chk("lim_total", issued, TOTAL);
    sel = 0;

    // reset mid-job with three issues outstanding
    hold = 1;
    start_job(0, 1, 2, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 20 && issued < 3; i++) step();
    step();
    rst = 1;
    #1;
    chk("midrst_issue", 32'({iv_a, nb_a, nonce_a}), 32'(0));
    chk("midrst_found", 32'({fv_a, fn_a}), 32'(0));
    chk("midrst_done_busy", 32'({done_a, busy_a}), 32'(0));
    chk("midrst_ready", 32'(ready_a), 32'(1));
    job_active = 0; exp_found = 0; want_job = 0;
    #1 rst = 0;
    hold = 0;
    for (int unsigned i = 0; i < 20 && q.size() != 0; i++) step();
    step();
    start_job(0, 2, 0, 0, 0, 0, 1);
    wait_done(100);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
